// File: rtl/instr_pkg.sv
// ============================================================================
// Package : instr_pkg
// Purpose : Shared instruction kinds, RV32I opcodes and loader FSM states.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package instr_pkg;

  typedef enum logic [2:0] {
    KIND_LW  = 3'd0,
    KIND_SW  = 3'd1,
    KIND_R   = 3'd2,
    KIND_B   = 3'd3,
    KIND_I   = 3'd4,
    KIND_JAL = 3'd5
  } kind_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Shift-immediate forms (slli/srli/srai) reuse the funct7 layout of R-type.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encode_loader_if.sv
// ============================================================================
// Interface : instr_encode_loader_if
// Purpose   : Field-level instruction request channel with valid/ready.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface instr_encode_loader_if;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [2:0]  req_funct3;
  logic        req_f7b5;
  logic [31:0] req_imm;

  modport master (
    output req_valid,
    output req_kind,
    output req_rd,
    output req_rs1,
    output req_rs2,
    output req_funct3,
    output req_f7b5,
    output req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_kind,
    input  req_rd,
    input  req_rs1,
    input  req_rs2,
    input  req_funct3,
    input  req_f7b5,
    input  req_imm,
    output req_ready
  );

endinterface

`default_nettype wire

// File: rtl/instr_encode_loader_packer.sv
// ============================================================================
// Module  : instr_packer
// Purpose : Combinational packing of request fields into an RV32I word.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module instr_packer
  import instr_pkg::*;
(
  input  logic [2:0]  i_kind,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic        i_f7b5,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  logic w_shift;
  logic w_unused_imm;

  assign w_shift      = is_shift_f3(i_funct3);
  // Immediate bits beyond the widest (JAL) field are silently dropped.
  assign w_unused_imm = &{1'b0, i_imm[31:21]};

  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (i_kind)
      KIND_LW: begin
        o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
      end
      KIND_SW: begin
        o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
      end
      KIND_R: begin
        o_word = {1'b0, i_f7b5, 5'b00000, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
      end
      KIND_I: begin
        if (w_shift) begin
          o_word = {1'b0, i_f7b5, 5'b00000, i_imm[4:0], i_rs1, i_funct3, i_rd, OP_IMM};
        end else begin
          o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_IMM};
        end
      end
      KIND_B: begin
        o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                     i_imm[4:1], i_imm[11], OP_BRANCH};
        o_illegal = i_imm[0];
      end
      KIND_JAL: begin
        o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
        o_illegal = i_imm[0];
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encode_loader.sv
// ============================================================================
// Module  : instr_encode_loader
// Purpose : Encodes requests and writes them to consecutive imem words.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module instr_encode_loader
  import instr_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  instr_encode_loader_if.slave  req,
  output logic                  imem_we,
  output logic [AW-1:0]         imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [AW:0]           word_count,
  output logic                  full,
  output logic                  err
);

  localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic [AW:0]   w_count_inc;
  logic [31:0]   r_wdata;
  logic [31:0]   w_wdata_nxt;
  logic [31:0]   w_word;
  logic          r_err;
  logic          w_err_nxt;
  logic          w_illegal;
  logic          w_fire;

  instr_packer u_packer (
    .i_kind    (req.req_kind),
    .i_rd      (req.req_rd),
    .i_rs1     (req.req_rs1),
    .i_rs2     (req.req_rs2),
    .i_funct3  (req.req_funct3),
    .i_f7b5    (req.req_f7b5),
    .i_imm     (req.req_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // rst_n gating keeps ready low while reset is held, not just after it.
  assign req.req_ready = rst_n && (r_state == ST_IDLE);
  assign w_fire        = req.req_valid && req.req_ready;
  assign w_count_inc   = r_count + 1'b1;

  assign imem_we    = (r_state == ST_WRITE) && !clear;
  assign imem_addr  = r_ptr;
  assign imem_wdata = r_wdata;
  assign word_count = r_count;
  assign full       = (r_state == ST_FULL);
  assign err        = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_wdata_nxt = r_wdata;
    w_err_nxt   = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_ptr_nxt   = '0;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            if (w_illegal) begin
              w_err_nxt = 1'b1;
            end else begin
              w_wdata_nxt = w_word;
              w_state_nxt = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          w_ptr_nxt   = r_ptr + 1'b1;
          w_count_nxt = w_count_inc;
          w_state_nxt = (w_count_inc == c_depth) ? ST_FULL : ST_IDLE;
        end
        ST_FULL: begin
          w_state_nxt = ST_FULL;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
      r_wdata <= w_wdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Sequential instruction encoder and instruction-memory loader: the encoding counterpart of the controller's opcode decode.
- Accepts field-level instruction requests (kind, registers, funct3, immediate) over a valid/ready handshake.
- Packs each request into a 32-bit RV32I machine word for the formats the core executes (lw, sw, R, B, I, jal).
- Writes words to consecutive instruction-memory addresses through a single write port. Used by the bench and by boot/self-test loading.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words.
- AW, $clog2(DEPTH), word-address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous restart: pointer to 0, count to 0, state to IDLE.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid & req_ready.
- req_kind  input  3  instruction kind (package enum).
- req_rd  input  5  destination register.
- req_rs1  input  5  source register 1.
- req_rs2  input  5  source register 2.
- req_funct3  input  3  funct3 field.
- req_f7b5  input  1  instruction bit 30 (sub/sra/srai select).
- req_imm  input  32  byte immediate, sign-extended value.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  AW  word address.
- imem_wdata  output  32  encoded word.
- word_count  output  AW+1  number of words written.
- full  output  1  DEPTH words written.
- err  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset values: all outputs 0, state IDLE, pointer 0. req_ready reads 0 during reset.
- State machine:
  - IDLE: req_ready=1. On handshake, encode combinationally and register the word into imem_wdata.
    - Legal request: go to WRITE.
    - Illegal request: stay in IDLE and pulse err next cycle. Illegal means kind > 5, or kind B/JAL with req_imm[0]=1.
  - WRITE: req_ready=0, imem_we=1, imem_addr=pointer. Next: pointer+1 and word_count+1. Go to FULL if the new count equals DEPTH, else IDLE.
  - FULL: req_ready=0, full=1. Leave only on clear or reset.
- Latency and throughput:
  - Handshake in cycle N -> imem_we high in cycle N+1 -> req_ready high again in N+2.
  - Throughput is one word per 2 cycles.
- Encodings (opcode in [6:0]):
  - LW: imm[11:0],rs1,f3,rd,0000011.
  - SW: imm[11:5],rs2,rs1,f3,imm[4:0],0100011.
  - R: 0,f7b5,00000,rs2,rs1,f3,rd,0110011.
  - I: imm[11:0],rs1,f3,rd,0010011. When f3=001/101, bits[31:25] = 0,f7b5,00000 and bits[24:20] = imm[4:0].
  - B: imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011.
  - JAL: imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111.
- Immediate bits above the field width are ignored; there is no range error.
- imem_wdata holds its last value outside WRITE. imem_we is never high outside WRITE.
- clear has priority over any handshake in the same cycle; that request is dropped.
- Asserting clear during WRITE suppresses that write.
- Reset mid-WRITE: the write is abandoned and the pointer returns to 0.
- Pointer wraps only via clear. DEPTH writes always land in FULL, never wrap to address 0.

Decomposition:
- Shared package instr_pkg:
  - kind enum: KIND_LW=0, SW=1, R=2, B=3, I=4, JAL=5.
  - opcode constants: OP_LOAD, OP_STORE, OP_R, OP_BRANCH, OP_IMM, OP_JAL.
  - FSM state enum.
- One combinational sub-module, instr_packer, maps the request fields to the 32-bit word plus an illegal flag.
- The top holds the FSM, pointer and count.

Test Plan:
- addi x1,x0,5 (kind I, rd=1, f3=0, imm=5) -> imem_we in cycle N+1, addr 0, data 0x00500093; word_count=1.
- lw x2,8(x1) then sw x2,12(x1), back-to-back valid:
  - lw -> 0x0080A103 at addr 1.
  - sw -> 0x0020A623 at addr 2.
  - req_ready low every WRITE cycle.
- sub x3,x1,x2 (f7b5=1) -> 0x402081B3.
- beq x1,x2,-4 -> 0xFE208EE3.
- jal x1,8 -> 0x008000EF.
- beq with imm=3 -> err pulse, no imem_we, count unchanged.
- DEPTH=4: four legal requests -> full=1 and req_ready=0 after the 4th write, with further valid ignored. Then clear -> next request writes addr 0.
- rst_n low during WRITE -> imem_we drops immediately, count=0; first post-reset write goes to addr 0.
